// File: rtl/dunc16_mem_responder.sv
// Wait-state memory responder for the dunc16 CPU bus: latches one request, accesses the array after WAIT_STATES cycles, pulses ACK.
// Optional write protection of the low ROM_TOP words is compiled in with DUNC16_MEM_WPROT_EN.
module dunc16_mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int WAIT_STATES = 2,
    parameter int ROM_TOP     = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              ACK,
    output logic              BUSY,
    input  logic              WPROT,
    output logic              ERR
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                prot_q, prot_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                acc_en, acc_we, acc_prot;
    logic [IDX_W-1:0]    acc_idx;
    logic [DATA_W-1:0]   acc_wdata;
    logic                blocked, wr_en;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        prot_d    = prot_q;
        acc_en    = 1'b0;
        acc_we    = we_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_prot  = prot_q;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    we_d    = WE;
                    idx_d   = ADDR[IDX_W-1:0];
                    wdata_d = WDATA;
                    prot_d  = WPROT;
                    if (WAIT_STATES == 0) begin
                        // zero wait states: access straight from the bus on the accepting edge
                        acc_en    = 1'b1;
                        acc_we    = WE;
                        acc_idx   = ADDR[IDX_W-1:0];
                        acc_wdata = WDATA;
                        acc_prot  = WPROT;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    acc_en  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DUNC16_MEM_WPROT_EN
    assign blocked = acc_en & acc_we & acc_prot & (32'(acc_idx) < 32'(ROM_TOP));
`else
    logic unused_prot;
    assign unused_prot = acc_prot;
    assign blocked     = 1'b0;
`endif

    assign wr_en = acc_en & acc_we & ~blocked;

    always_comb begin
        rdata_d = rdata_q;
        if (acc_en && !acc_we) rdata_d = mem[acc_idx];
        // set on the access edge so it is visible exactly in the ACK cycle
        err_d = blocked;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            prot_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            prot_q  <= prot_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // array is deliberately outside the reset domain: contents survive RESET
    always_ff @(posedge CLK) begin
        if (wr_en) mem[acc_idx] <= acc_wdata;
    end

    logic unused_addr;
    assign unused_addr = ^ADDR;

    assign ACK   = (state_q == S_RESP);
    assign BUSY  = (state_q != S_IDLE);
    assign RDATA = rdata_q;
    assign ERR   = err_q;
endmodule

// File: tb/tb_dunc16_mem_responder.sv
// Self-checking bench for dunc16_mem_responder (DEPTH=256, WAIT_STATES=2): directed table, corner sequences, random vs model.
module tb_dunc16_mem_responder;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        REQ = 1'b0, WE = 1'b0, WPROT = 1'b0;
    logic [11:0] ADDR = '0;
    logic [15:0] WDATA = '0;
    logic [15:0] RDATA;
    logic        ACK, BUSY, ERR;

    dunc16_mem_responder #(.DATA_W(16), .ADDR_W(12), .DEPTH(256), .WAIT_STATES(2), .ROM_TOP(16)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDR(ADDR), .WDATA(WDATA),
        .RDATA(RDATA), .ACK(ACK), .BUSY(BUSY), .WPROT(WPROT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: word array indexed by address mod 256, plus the last read result
    logic [15:0] mdl [256];
    bit          known [256];
    logic [15:0] mrd;
    bit          mrd_known;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_err(input bit we, input logic [11:0] addr, input bit wprot);
`ifdef DUNC16_MEM_WPROT_EN
        return we && wprot && ((int'(addr) % 256) < 16);
`else
        return 1'b0;
`endif
    endfunction

    // one full transaction; REQ dropped right after acceptance, bus scrambled to prove latching
    task automatic do_txn(input bit we, input logic [11:0] addr, input logic [15:0] wd, input bit wprot,
                          output logic [15:0] rd, output logic er);
        int n;
        int idx;
        bit e;
        REQ = 1'b1; WE = we; ADDR = addr; WDATA = wd; WPROT = wprot;
        @(posedge CLK); #1;
        REQ = 1'b0; WE = 1'($urandom); ADDR = 12'($urandom); WDATA = 16'($urandom); WPROT = 1'($urandom);
        chk("busy_accept", BUSY, 1);
        n = 0;
        while (!ACK && n < 10) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("ack_latency", n, 2);
        rd = RDATA;
        er = ERR;
        idx = int'(addr) % 256;
        e = exp_err(we, addr, wprot);
        chk("err", ERR, e);
        if (we) begin
            if (!e) begin
                mdl[idx] = wd;
                known[idx] = 1'b1;
            end
        end else begin
            mrd = mdl[idx];
            mrd_known = known[idx];
        end
        if (mrd_known) chk("rdata", RDATA, mrd);
        @(posedge CLK); #1;
        chk("ack_pulse", ACK, 0);
        chk("busy_idle", BUSY, 0);
        chk("err_idle", ERR, 0);
    endtask

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [12];
        logic [15:0] rd;
        logic        er;
        int          acks;
        int          ack_c [2];
        logic [15:0] ack_d [2];

        tbl[0]  = '{1'b1, 12'h005, 16'hBEEF, 16'h0000};
        tbl[1]  = '{1'b0, 12'h005, 16'h0000, 16'hBEEF};
        tbl[2]  = '{1'b1, 12'h001, 16'h1111, 16'h0000};
        tbl[3]  = '{1'b1, 12'h002, 16'h2222, 16'h0000};
        tbl[4]  = '{1'b1, 12'h020, 16'h00AA, 16'h0000};
        tbl[5]  = '{1'b0, 12'h020, 16'h0000, 16'h00AA};
        tbl[6]  = '{1'b1, 12'h1FF, 16'hA5A5, 16'h0000};
        tbl[7]  = '{1'b0, 12'h0FF, 16'h0000, 16'hA5A5};
        tbl[8]  = '{1'b1, 12'h010, 16'h1234, 16'h0000};
        tbl[9]  = '{1'b1, 12'h003, 16'h0042, 16'h0000};
        tbl[10] = '{1'b0, 12'h003, 16'h0000, 16'h0042};
        tbl[11] = '{1'b0, 12'h001, 16'h0000, 16'h1111};

        for (int i = 0; i < 256; i++) known[i] = 1'b0;
        mrd = 16'h0000;
        mrd_known = 1'b1;

        // reset state
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ack", ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_err", ERR, 0);
        chk("rst_rdata", RDATA, 16'h0000);
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("idle_busy", BUSY, 0);

        // directed table
        for (int i = 0; i < 12; i++) begin
            do_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, rd, er);
            chk("tbl_err", er, 0);
            if (!tbl[i].we) chk($sformatf("tbl_rd[%0d]", i), rd, tbl[i].exp_rd);
        end

        // back-to-back reads with REQ held: ACK at +2 and +6 edges after acceptance
        REQ = 1'b1; WE = 1'b0; ADDR = 12'h001;
        @(posedge CLK); #1;
        ADDR = 12'h002;
        acks = 0;
        ack_c[0] = -1; ack_c[1] = -1; ack_d[0] = '0; ack_d[1] = '0;
        for (int c = 0; c < 10; c++) begin
            if (ACK) begin
                if (acks < 2) begin
                    ack_c[acks] = c;
                    ack_d[acks] = RDATA;
                end
                acks++;
                if (acks == 2) REQ = 1'b0;
            end
            @(posedge CLK); #1;
        end
        chk("b2b_count", acks, 2);
        chk("b2b_c0", ack_c[0], 2);
        chk("b2b_c1", ack_c[1], 6);
        chk("b2b_d0", ack_d[0], 16'h1111);
        chk("b2b_d1", ack_d[1], 16'h2222);
        mrd = 16'h2222;
        mrd_known = 1'b1;

        // reset during WAIT aborts the write
        REQ = 1'b1; WE = 1'b1; ADDR = 12'h010; WDATA = 16'h5678;
        @(posedge CLK); #1;
        REQ = 1'b0;
        chk("mid_busy", BUSY, 1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_ack", ACK, 0);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_rdata", RDATA, 16'h0000);
        repeat (3) begin
            @(posedge CLK); #1;
            chk("mid_no_ack", ACK, 0);
        end
        RESET = 1'b1;
        mrd = 16'h0000;
        @(posedge CLK); #1;
        chk("post_rst_busy", BUSY, 0);
        do_txn(1'b0, 12'h010, 16'h0000, 1'b0, rd, er);
        chk("abort_rd", rd, 16'h1234);

        // write protection of low words
        do_txn(1'b1, 12'h003, 16'hFFFF, 1'b1, rd, er);
`ifdef DUNC16_MEM_WPROT_EN
        chk("prot_err", er, 1);
        do_txn(1'b0, 12'h003, 16'h0000, 1'b0, rd, er);
        chk("prot_rd", rd, 16'h0042);
`else
        chk("prot_err", er, 0);
        do_txn(1'b0, 12'h003, 16'h0000, 1'b0, rd, er);
        chk("prot_rd", rd, 16'hFFFF);
`endif
        do_txn(1'b1, 12'h120, 16'h7777, 1'b1, rd, er);
        chk("prot_hi_err", er, 0);
        do_txn(1'b0, 12'h020, 16'h0000, 1'b1, rd, er);
        chk("prot_hi_rd", rd, 16'h7777);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            bit          we, wp;
            logic [11:0] a;
            we = 1'($urandom_range(0, 1));
            wp = 1'($urandom_range(0, 1));
            a  = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) a[7:0] = 8'($urandom_range(0, 31));
            do_txn(we, a, 16'($urandom), wp, rd, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/dunc16_mem_responder.md
Name: dunc16_mem_responder

Overview:
- Memory-side responder for the dunc16 accumulator CPU's memory bus; the CPU is the initiator.
- Accepts single-word read/write requests (address from MA, write data from MD, write strobe) and services them from an internal word array after a programmable number of wait states.
- Returns read data with a one-cycle ACK pulse.
- Replaces the zero-latency combinational memory, so the CPU sequencer can be verified against slow memory.

Parameters:
- DATA_W, 16, word width.
- ADDR_W, 12, request address width (operand field of a 16-bit instruction).
- DEPTH, 4096, words in the array; power of two, at most 2^ADDR_W.
- WAIT_STATES, 2, extra cycles between acceptance and array access; range 0..15.
- ROM_TOP, 16, used only with the optional feature: addresses below this are write-protected.

Ports:
- CLK  in  1  clock, rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- REQ  in  1  request valid, level.
- WE  in  1  1 = write, 0 = read; sampled with REQ.
- ADDR  in  ADDR_W  word address.
- WDATA  in  DATA_W  write data.
- RDATA  out  DATA_W  read data; valid while ACK=1 for a read.
- ACK  out  1  one-cycle completion pulse.
- BUSY  out  1  high whenever the FSM is not IDLE.
- WPROT  in  1  write-protect enable; ignored unless the optional feature is compiled in.
- ERR  out  1  protection-violation flag, pulses with ACK; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (RESET=0, asynchronous):
  - FSM goes to IDLE.
  - ACK=0, BUSY=0, ERR=0, RDATA=0, wait counter=0.
  - Array contents are not cleared.
  - A pending transaction is aborted; an uncommitted write never reaches the array.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - REQ is sampled only in IDLE.
  - At a rising edge k with REQ=1, latch WE, ADDR and WDATA.
  - If WAIT_STATES>0, go to WAIT with counter = WAIT_STATES-1.
  - If WAIT_STATES=0, perform the access at edge k and go directly to RESP.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter is 0, perform the access and go to RESP.
- Access, done on a single edge:
  - Write: array[latched ADDR mod DEPTH] <= latched WDATA.
  - Read: RDATA <= array[latched ADDR mod DEPTH].
  - Address bits at or above log2(DEPTH) are ignored (wrap-around).
- RESP:
  - ACK=1 for exactly this cycle; next edge returns to IDLE.
- Latency: ACK is high during the cycle following edge k+WAIT_STATES. Minimum request-to-request period is WAIT_STATES+2 cycles.
- RDATA:
  - Holds the last read result until the next read completes.
  - Writes do not change RDATA.
  - Read-after-write to the same address returns the new data.
- REQ deasserted during WAIT: the transaction is committed and still completes with ACK.
- REQ held high through RESP: treated as a new request when sampled in IDLE on the following edge. The initiator must drop REQ on seeing ACK if it wants only one access.
- ADDR, WDATA and WE changes after acceptance have no effect.
- Reset asserted during WAIT or RESP: aborts immediately; no ACK is issued.

Optional Feature:
- Macro: DUNC16_MEM_WPROT_EN.
- Defined:
  - A write with WPROT=1 and (ADDR mod DEPTH) < ROM_TOP is suppressed; the array is unchanged.
  - The transaction still completes with normal latency; ERR=1 during the same cycle as ACK.
  - Reads are never blocked.
- Undefined: WPROT is ignored, all writes commit, ERR is constant 0.

Test Plan:
- Reset: hold RESET=0 for 2 cycles -> ACK=0, BUSY=0, ERR=0, RDATA=0x0000. After release, BUSY stays 0 with REQ=0.
- Write/read, WAIT_STATES=2:
  - Write ADDR=0x005, WDATA=0xBEEF accepted at edge k -> ACK high only in the cycle after edge k+2; BUSY high from k to k+3.
  - Then read 0x005 -> RDATA=0xBEEF while ACK=1.
- Back-to-back: REQ held high for two reads, 0x001 (=0x1111) then 0x002 (=0x2222) -> two single-cycle ACK pulses 4 cycles apart, with RDATA 0x1111 then 0x2222.
- Withdrawal:
  - Write 0x020 <- 0x00AA, REQ dropped one cycle after acceptance -> ACK still pulses at k+2.
  - A subsequent read of 0x020 returns 0x00AA.
- Reset mid-operation:
  - 0x010 holds 0x1234. Write 0x010 <- 0x5678, assert RESET during WAIT -> no ACK, BUSY=0.
  - After release, a read of 0x010 returns 0x1234.
- Wrap and protection:
  - With DEPTH=256, write 0x1FF <- 0xA5A5, then read 0x0FF -> 0xA5A5.
  - With DUNC16_MEM_WPROT_EN defined, WPROT=1, ROM_TOP=16: write 0x003 <- 0xFFFF -> ERR=1 with ACK, and a read of 0x003 returns the old value.
